// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO plus transmit scheduler for the serial echo path. Bytes from the
//   UART receiver are buffered on each data-ready strobe. They are then handed
//   to the transmitter one at a time. A new start is issued only once the
//   transmitter reports idle, so no byte is lost while a frame is in flight.
//
// Parameters
//   DATA_WIDTH   width of one buffered word
//   DEPTH_LOG2   log2 of the FIFO depth
//   ACK_TIMEOUT  cycles to wait for i_tx_busy to rise after a start
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_rx_data    byte from receiver, qualified by i_rx_valid
//   i_rx_valid   one-cycle receive strobe
//   i_tx_busy    transmitter busy
//   i_clear_ovf  synchronous clear of the sticky overflow flag
//   o_tx_data    byte to transmitter, held from one pop to the next
//   o_tx_start   one-cycle start strobe to transmitter
//   o_count      FIFO occupancy, 0..2**DEPTH_LOG2
//   o_full       occupancy equals depth
//   o_empty      occupancy is zero
//   o_overflow   sticky: a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_tx_busy,
    input  logic                  i_clear_ovf,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow
);

    localparam int                DEPTH  = 1 << DEPTH_LOG2;
    localparam int                TMR_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [DEPTH_LOG2:0] C_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TMR_W-1:0]  C_TMO_LAST = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    state_t                r_state;
    logic [TMR_W-1:0]      r_timer;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_start;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_pop;

    // Flags come from the registered count, so a byte written this cycle is
    // not visible to the pop decision until the next one.
    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);
    assign w_wr    = i_rx_valid & ~w_full;
    assign w_pop   = (r_state == IDLE) & ~w_empty & ~i_tx_busy;

    // Storage carries no reset; stale entries are unreachable once the
    // pointers are cleared.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear request wins.
            if (i_rx_valid && w_full) begin
                r_overflow <= 1'b1;
            end else if (i_clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx_start <= 1'b0;
                    if (w_pop) begin
                        r_tx_data  <= r_mem[r_rd_ptr];
                        r_tx_start <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_tx_start <= 1'b0;
                    r_timer    <= '0;
                    r_state    <= ACK;
                end
                ACK: begin
                    // Busy never rising is treated as a completed send so a
                    // missing transmitter cannot stall the queue.
                    if (i_tx_busy) begin
                        r_state <= DRAIN;
                    end else if (r_timer == C_TMO_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!i_tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx_start <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule
